// File: rtl/radio_uplink_tx_if.sv
// Host write channel for the radio uplink encoder.
// The host offers 14-bit command words over a valid/ready handshake.
interface radio_uplink_tx_if;
  logic [13:0] wr_data;
  logic        wr_bad_parity;
  logic        wr_valid;
  logic        wr_ready;

  modport master (
    output wr_data,
    output wr_bad_parity,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_bad_parity,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/radio_uplink_tx.sv
// Uplink frame encoder: one sync pulse, then seven 2-bit data pulses.
// A holding register double-buffers host words so frames can run back to back.
module radio_uplink_tx #(
  parameter int LEAD    = 2,
  parameter int HI      = 2,
  parameter int SYNC_HI = 3,
  parameter int TAIL    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  radio_uplink_tx_if.slave  wr,
  input  logic              abort,
  output logic              RPULSE,
  output logic              RD1,
  output logic              RD0,
  output logic              RCHECK,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SLEAD, S_SHI, S_DLEAD, S_DHI, S_TAIL
  } state_e;

  localparam logic [7:0] L_LEAD = 8'(LEAD - 1);
  localparam logic [7:0] L_HI   = 8'(HI - 1);
  localparam logic [7:0] L_SHI  = 8'(SYNC_HI - 1);
  localparam logic [7:0] L_TAIL = 8'(TAIL - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [13:0] sh_q, sh_d;
  logic        shbad_q, shbad_d;
  logic [13:0] hold_q, hold_d;
  logic        hbad_q, hbad_d;
  logic        hfull_q, hfull_d;
  logic        ab_q, ab_d;
  logic        rdy_q;
  logic        rp_q, d1_q, d0_q, ck_q, busy_q, fd_q;
  logic        rp_d, d1_d, d0_d, ck_d, busy_d, fd_d;
  logic        xfer, acc, last, sync_d, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    shbad_d = shbad_q;
    ab_d    = ab_q;
    xfer    = 1'b0;
    last    = (cnt_q == 8'd0);
    acc     = wr.wr_valid & rdy_q;

    if (abort && state_q != S_IDLE) begin
      state_d = S_TAIL;
      cnt_d   = L_TAIL;
      ab_d    = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = cnt_q;
          xfer  = hfull_q;
        end
        S_SLEAD: if (last) begin
          state_d = S_SHI;
          cnt_d   = L_SHI;
        end
        S_SHI: if (last) begin
          state_d = S_DLEAD;
          cnt_d   = L_LEAD;
        end
        S_DLEAD: if (last) begin
          state_d = S_DHI;
          cnt_d   = L_HI;
        end
        S_DHI: if (last) begin
          sh_d  = {sh_q[11:0], 2'b00};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd6) begin
            state_d = S_TAIL;
            cnt_d   = L_TAIL;
          end else begin
            state_d = S_DLEAD;
            cnt_d   = L_LEAD;
          end
        end
        S_TAIL: if (last) begin
          ab_d = 1'b0;
          if (hfull_q) begin
            xfer = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end

    // frame start: shift register takes the older word
    if (xfer) begin
      state_d = S_SLEAD;
      cnt_d   = L_LEAD;
      sh_d    = hold_q;
      shbad_d = hbad_q;
      idx_d   = 3'd0;
      ab_d    = 1'b0;
    end

    hold_d  = acc ? wr.wr_data : hold_q;
    hbad_d  = acc ? wr.wr_bad_parity : hbad_q;
    hfull_d = acc | (hfull_q & ~xfer);

    sync_d = (state_d == S_SLEAD) || (state_d == S_SHI);
    data_d = (state_d == S_DLEAD) || (state_d == S_DHI);
    rp_d   = (state_d == S_SHI) || (state_d == S_DHI);
    d1_d   = sync_d | (data_d & sh_d[13]);
    d0_d   = sync_d | (data_d & sh_d[12]);
    ck_d   = sync_d | (data_d & (sh_d[13] ^ sh_d[12] ^ shbad_d));
    busy_d = (state_d != S_IDLE);
    fd_d   = (state_d == S_TAIL) && (cnt_d == 8'd0) && !ab_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      sh_q    <= 14'd0;
      shbad_q <= 1'b0;
      hold_q  <= 14'd0;
      hbad_q  <= 1'b0;
      hfull_q <= 1'b0;
      ab_q    <= 1'b0;
      rdy_q   <= 1'b1;
      rp_q    <= 1'b0;
      d1_q    <= 1'b0;
      d0_q    <= 1'b0;
      ck_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      shbad_q <= shbad_d;
      hold_q  <= hold_d;
      hbad_q  <= hbad_d;
      hfull_q <= hfull_d;
      ab_q    <= ab_d;
      rdy_q   <= ~hfull_d;
      rp_q    <= rp_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      ck_q    <= ck_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign wr.wr_ready = rdy_q;
  assign RPULSE      = rp_q;
  assign RD1         = d1_q;
  assign RD0         = d0_q;
  assign RCHECK      = ck_q;
  assign busy        = busy_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_radio_uplink_tx.sv
// Bench for radio_uplink_tx: waveform-level frame model plus a receiver
// model that decodes pulses back into words.
module tb_radio_uplink_tx;

  localparam int LEAD = 2, HI = 2, SYNC_HI = 3, TAIL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic RPULSE, RD1, RD0, RCHECK, busy, frame_done;

  radio_uplink_tx_if wr_if ();

  radio_uplink_tx #(
    .LEAD(LEAD), .HI(HI), .SYNC_HI(SYNC_HI), .TAIL(TAIL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr_if), .abort(abort),
    .RPULSE(RPULSE), .RD1(RD1), .RD0(RD0), .RCHECK(RCHECK),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // model: {RPULSE,RD1,RD0,RCHECK,busy,frame_done} per cycle
  logic [5:0]  q [$];
  logic [5:0]  cur = 6'd0;
  logic        m_hfull = 1'b0;
  logic [13:0] m_hword = 14'd0;
  logic        m_hbad = 1'b0;
  logic        m_ready = 1'b1;
  int          cyc = 0;

  task automatic build(input logic [13:0] w, input logic bad);
    logic [1:0] p;
    logic c;
    for (int i = 0; i < LEAD; i++) q.push_back(6'b011110);
    for (int i = 0; i < SYNC_HI; i++) q.push_back(6'b111110);
    for (int k = 0; k < 7; k++) begin
      p = w[13 - 2*k -: 2];
      c = p[1] ^ p[0] ^ bad;
      for (int i = 0; i < LEAD; i++) q.push_back({1'b0, p, c, 2'b10});
      for (int i = 0; i < HI; i++) q.push_back({1'b1, p, c, 2'b10});
    end
    for (int i = 0; i < TAIL - 1; i++) q.push_back(6'b000010);
    q.push_back(6'b000011);
  endtask

  initial begin
    logic a;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        cur = 6'd0;
        m_hfull = 1'b0;
        m_ready = 1'b1;
      end else begin
        cyc++;
        a = wr_if.wr_valid && m_ready;
        if (abort && cur[1]) begin
          q.delete();
          for (int i = 0; i < TAIL; i++) q.push_back(6'b000010);
        end else if (q.size() == 0 && m_hfull) begin
          build(m_hword, m_hbad);
          m_hfull = 1'b0;
        end
        if (a) begin
          m_hfull = 1'b1;
          m_hword = wr_if.wr_data;
          m_hbad  = wr_if.wr_bad_parity;
        end
        cur = (q.size() != 0) ? q.pop_front() : 6'd0;
        m_ready = !m_hfull;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk($sformatf("cyc%0d outputs", cyc),
          {26'd0, RPULSE, RD1, RD0, RCHECK, busy, frame_done},
          {26'd0, cur});
      chk($sformatf("cyc%0d wr_ready", cyc), {31'd0, wr_if.wr_ready},
          {31'd0, m_ready});
    end
  end

  // receiver model and pulse log
  logic [2:0]  pulses [0:15];
  int          npulse = 0, nsync = 0, nfd = 0;
  int          syncrise = 0, sync_len = 0, fd_cyc = 0;
  logic [13:0] rx_word = 14'd0;
  int          rx_cnt = 0;
  logic        rx_err = 1'b0, rx_irq = 1'b0;

  initial begin
    logic prev_rp, in_sync;
    prev_rp = 1'b0;
    in_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rp = 1'b0;
        in_sync = 1'b0;
      end else begin
        if (RPULSE && !prev_rp) begin
          if (RD1 && RD0 && RCHECK) begin
            syncrise = cyc;
            nsync++;
            npulse = 0;
            rx_word = 14'd0;
            rx_cnt = 0;
            rx_err = 1'b0;
            rx_irq = 1'b0;
            in_sync = 1'b1;
          end else begin
            if (npulse < 16) pulses[npulse] = {RD1, RD0, RCHECK};
            npulse++;
            if (RCHECK != (RD1 ^ RD0)) rx_err = 1'b1;
            rx_word = {rx_word[11:0], RD1, RD0};
            rx_cnt++;
            if (rx_cnt == 7 && !rx_err) rx_irq = 1'b1;
          end
        end
        if (!RPULSE && prev_rp && in_sync) begin
          sync_len = cyc - syncrise;
          in_sync = 1'b0;
        end
        if (frame_done) begin
          nfd++;
          fd_cyc = cyc;
        end
        prev_rp = RPULSE;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input logic [13:0] d, input logic b, output int ac);
    int n;
    tick();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data = d;
    wr_if.wr_bad_parity = b;
    n = 0;
    while (!wr_if.wr_ready && n < 200) begin
      tick();
      n++;
    end
    chk("write timeout", {31'd0, n < 200}, 32'd1);
    @(posedge clk);
    #1;
    ac = cyc;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_fd(input int target, input string nm);
    int n = 0;
    while (nfd < target && n < 300) begin
      tick();
      n++;
    end
    chk({nm, " frame_done wait"}, {31'd0, nfd >= target}, 32'd1);
  endtask

  task automatic wait_sync(input int target);
    int n = 0;
    while (nsync < target && n < 300) begin
      tick();
      n++;
    end
    chk("sync wait", {31'd0, nsync >= target}, 32'd1);
  endtask

  task automatic wait_pulse(input int target);
    int n = 0;
    while (npulse < target && n < 300) begin
      tick();
      n++;
    end
    chk("pulse wait", {31'd0, npulse >= target}, 32'd1);
  endtask

  task automatic chk_pairs(input string nm, input logic [2:0] e [0:6]);
    chk({nm, " pulse count"}, npulse, 32'd7);
    for (int k = 0; k < 7; k++)
      chk($sformatf("%s pair%0d", nm, k), {29'd0, pulses[k]}, {29'd0, e[k]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2, n0, s0, f1, ab_cyc;
    logic [2:0] e1 [0:6];
    logic [2:0] e2 [0:6];
    logic [2:0] e3 [0:6];
    e1 = '{3'b101, 3'b110, 3'b000, 3'b000, 3'b110, 3'b011, 3'b011};
    e2 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    e3 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data = 14'd0;
    wr_if.wr_bad_parity = 1'b0;
    repeat (3) tick();
    chk("reset lines", {28'd0, RPULSE, RD1, RD0, RCHECK}, 32'd0);
    chk("reset busy/done", {30'd0, busy, frame_done}, 32'd0);
    chk("reset wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (2) tick();

    // single word
    n0 = nfd;
    write(14'h2C35, 1'b0, acc);
    wait_fd(n0 + 1, "t1");
    chk("t1 first rise", syncrise - acc, 32'd3);
    chk("t1 sync len", sync_len, 32'd3);
    chk("t1 frame_done time", fd_cyc - acc, 32'd35);
    chk_pairs("t1", e1);
    chk("t1 rx word", {18'd0, rx_word}, 32'h2C35);
    chk("t1 rx irq", {31'd0, rx_irq}, 32'd1);
    repeat (3) tick();

    // abort while idle does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();

    // bad parity
    n0 = nfd;
    write(14'h0000, 1'b1, acc);
    wait_fd(n0 + 1, "t2");
    chk_pairs("t2", e2);
    chk("t2 rx irq", {31'd0, rx_irq}, 32'd0);
    repeat (2) tick();

    // back to back
    n0 = nfd;
    write(14'h3FFF, 1'b0, acc);
    write(14'h0001, 1'b0, acc2);
    chk("t3 second accept", acc2 - acc, 32'd2);
    wait_fd(n0 + 1, "t3a");
    f1 = fd_cyc;
    wait_fd(n0 + 2, "t3b");
    chk("t3 frame spacing", fd_cyc - f1, 32'd35);
    chk_pairs("t3", e3);
    chk("t3 rx word", {18'd0, rx_word}, 32'h0001);
    repeat (2) tick();

    // abort on pair 2 high, queued word follows
    n0 = nfd;
    s0 = nsync;
    write(14'h1555, 1'b0, acc);
    write(14'h2AAA, 1'b0, acc2);
    wait_sync(s0 + 1);
    wait_pulse(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ab_cyc = cyc;
    wait_sync(s0 + 2);
    chk("t4 restart delay", syncrise - ab_cyc, 32'd4);
    wait_fd(n0 + 1, "t4");
    repeat (3) tick();
    chk("t4 frame_done count", nfd - n0, 32'd1);
    chk("t4 rx word", {18'd0, rx_word}, 32'h2AAA);
    chk("t4 rx irq", {31'd0, rx_irq}, 32'd1);

    // reset during DATA_LEAD with a word held
    n0 = nfd;
    s0 = nsync;
    write(14'h0F0F, 1'b0, acc);
    write(14'h3333, 1'b0, acc2);
    wait_sync(s0 + 1);
    wait_pulse(1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5 lines in reset", {28'd0, RPULSE, RD1, RD0, RCHECK}, 32'd0);
    chk("t5 busy/done in reset", {30'd0, busy, frame_done}, 32'd0);
    chk("t5 wr_ready in reset", {31'd0, wr_if.wr_ready}, 32'd1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("t5 no frame after reset", nsync - s0, 32'd1);
    chk("t5 no frame_done", nfd - n0, 32'd0);

    // receiver loopback
    n0 = nfd;
    write(14'h1234, 1'b0, acc);
    wait_fd(n0 + 1, "t6");
    chk("t6 rx word", {18'd0, rx_word}, 32'h1234);
    chk("t6 rx irq", {31'd0, rx_irq}, 32'd1);
    write(14'h1234, 1'b1, acc);
    wait_fd(n0 + 2, "t6b");
    chk("t6 bad rx irq", {31'd0, rx_irq}, 32'd0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
